// File: rtl/dma_pkg.sv
// Shared definitions for the accelerator DMA engines: AXI encodings, the
// engine state encoding and the fixed AXI IDs of the input and output DMAs.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_ADDR = 2'd1,
        DMA_DATA = 2'd2,
        DMA_RESP = 2'd3
    } dma_state_e;

    localparam logic [7:0] IN_DMA_ID  = 8'h80;
    localparam logic [7:0] OUT_DMA_ID = 8'h81;

endpackage

// File: rtl/out_dma.sv
// AXI write-master that drains the accelerator output buffer to memory with
// one INCR burst per start, then reports completion and the write response.
//
// state    | meaning
// IDLE     | waiting for dma_start
// ADDR     | awvalid held until awready
// DATA     | streaming buffer words on W, wlast on beat len
// RESP     | waiting for a B response carrying our ID
module out_dma
    import dma_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 256,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] ID         = ID_WIDTH'(OUT_DMA_ID)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   dma_addr,
    input  logic [3:0]              dma_burst_len,
    input  logic                    dma_start,
    output logic                    dma_busy,
    output logic                    dma_done,
    output logic                    dma_err,

    input  logic [DATA_WIDTH-1:0]   out_buf_rd_data,
    input  logic                    out_buf_rd_valid,
    output logic                    out_buf_rd_ready,

    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int SIZE_BITS = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((64'd1 << SIZE_BITS) - 64'd1);

    dma_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [3:0]            cnt_q;
    logic                  err_q;

    logic in_data;
    logic in_resp;
    logic w_hs;
    logic b_hs;

    assign in_data = (state_q == DMA_DATA);
    assign in_resp = (state_q == DMA_RESP);

    // W channel is a zero-latency pass-through of the buffer head while in DATA
    assign wvalid           = in_data & out_buf_rd_valid;
    assign wdata            = in_data ? out_buf_rd_data : '0;
    assign out_buf_rd_ready = in_data & wready;
    assign wlast            = in_data & (cnt_q == len_q);
    assign wstrb            = '1;

    assign awid    = ID;
    assign awaddr  = addr_q;
    assign awlen   = {4'b0000, len_q};
    assign awsize  = 3'(SIZE_BITS);
    assign awburst = AXI_BURST_INCR;
    assign awvalid = (state_q == DMA_ADDR);

    // Responses for other masters sharing the port are left for them
    assign bready = in_resp & (bid == ID);

    assign w_hs = wvalid & wready;
    assign b_hs = bvalid & bready;

    // Done is asserted in the accepting cycle, while the state is still RESP
    assign dma_done = b_hs;
    assign dma_busy = (state_q != DMA_IDLE);
    assign dma_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                DMA_IDLE: begin
                    if (dma_start) begin
                        addr_q  <= dma_addr & ~OFFSET_MASK;
                        len_q   <= dma_burst_len;
                        err_q   <= 1'b0;
                        state_q <= DMA_ADDR;
                    end
                end
                DMA_ADDR: begin
                    if (awready) begin
                        cnt_q   <= '0;
                        state_q <= DMA_DATA;
                    end
                end
                DMA_DATA: begin
                    if (w_hs) begin
                        if (wlast) begin
                            state_q <= DMA_RESP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                DMA_RESP: begin
                    if (b_hs) begin
                        err_q   <= (bresp != AXI_RESP_OKAY);
                        state_q <= DMA_IDLE;
                    end
                end
                default: state_q <= DMA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_dma.sv
// Directed bench for out_dma: a bus monitor logs AW/W/B activity and buffer
// pops, and each scenario task checks the log and live outputs inline.
module tb_out_dma;
    import dma_pkg::*;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] dma_addr;
    logic [3:0]    dma_burst_len;
    logic          dma_start;
    logic          dma_busy, dma_done, dma_err;
    logic [DW-1:0] out_buf_rd_data;
    logic          out_buf_rd_valid, out_buf_rd_ready;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;

    out_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ID(8'h81)) dut (
        .clk(clk), .rst(rst),
        .dma_addr(dma_addr), .dma_burst_len(dma_burst_len), .dma_start(dma_start),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
        .out_buf_rd_data(out_buf_rd_data), .out_buf_rd_valid(out_buf_rd_valid),
        .out_buf_rd_ready(out_buf_rd_ready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int i);
        mk = {8{32'hD00D_0000 + 32'(i)}};
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0, aw_cnt = 0, beat_cnt = 0, pop_cnt = 0, done_cnt = 0, last_cnt = 0;
    int early_w = 0, stall_viol = 0, bad_pop = 0, buf_idx = 0;
    logic aw_done = 1'b0, pop_pend = 1'b0, stall_q = 1'b0;
    logic [DW-1:0] stall_data;
    logic [AW-1:0] aw_addr_log;
    logic [7:0]    aw_len_log;
    logic [DW-1:0] wdata_log [16];
    logic          last_log [16];
    int            beat_cyc [16];

    assign out_buf_rd_data = mk(buf_idx);

    // Inputs only change at posedge+1, so values seen here are what the next edge samples
    always @(negedge clk) begin
        cyc++;
        if (awvalid && awready) begin
            aw_cnt++;
            aw_addr_log = awaddr;
            aw_len_log  = awlen;
            aw_done     = 1'b1;
        end
        if (wvalid && !aw_done) early_w++;
        if (wvalid && wready) begin
            if (beat_cnt < 16) begin
                wdata_log[beat_cnt] = wdata;
                last_log[beat_cnt]  = wlast;
                beat_cyc[beat_cnt]  = cyc;
            end
            beat_cnt++;
            if (wlast) last_cnt++;
        end
        if (out_buf_rd_valid && out_buf_rd_ready) begin
            pop_cnt++;
            pop_pend = 1'b1;
            if (!(wvalid && wready)) bad_pop++;
        end
        if (stall_q && wvalid && (wdata !== stall_data)) stall_viol++;
        stall_q    = wvalid && !wready;
        stall_data = wdata;
        if (dma_done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            buf_idx++;
            pop_pend = 1'b0;
        end
    end

    task automatic pclk();
        @(posedge clk); #1;
    endtask

    task automatic nclk();
        @(negedge clk); #1;
    endtask

    task automatic clear_logs();
        aw_cnt = 0; beat_cnt = 0; pop_cnt = 0; done_cnt = 0; last_cnt = 0;
        early_w = 0; stall_viol = 0; bad_pop = 0; buf_idx = 0;
        aw_done = 1'b0; stall_q = 1'b0;
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input logic [3:0] l);
        pclk();
        dma_start = 1'b1; dma_addr = a; dma_burst_len = l;
        pclk();
        dma_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) pclk();
        nclk();
        n_checks++;
        if ({awvalid, wvalid, wlast, bready, out_buf_rd_ready, dma_busy, dma_done, dma_err} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                {awvalid, wvalid, wlast, bready, out_buf_rd_ready, dma_busy, dma_done, dma_err});
        end
        n_checks++;
        if (awaddr !== 32'h0 || awlen !== 8'h00) begin
            n_errors++; $display("FAIL reset_addr_len: got %h/%h want 0/0", awaddr, awlen);
        end
        n_checks++;
        if ({awid, awsize, awburst} !== {8'h81, 3'd5, 2'b01}) begin
            n_errors++; $display("FAIL aw_consts: got id %h size %0d burst %b want 81/5/01", awid, awsize, awburst);
        end
        n_checks++;
        if (wstrb !== {32{1'b1}}) begin
            n_errors++; $display("FAIL wstrb: got %h want all ones", wstrb);
        end
        pclk();
        rst = 1'b0;
        nclk();
        n_checks++;
        if (dma_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_release_busy: got %b want 0", dma_busy);
        end
    endtask

    task automatic test_single_beat();
        int k;
        pclk();
        awready = 1; wready = 1; out_buf_rd_valid = 1; bvalid = 1; bid = 8'h81; bresp = 2'b00;
        clear_logs();
        start_burst(32'h1000_0000, 4'd0);
        nclk();
        n_checks++;
        if (awvalid !== 1'b1) begin
            n_errors++; $display("FAIL single_awvalid_rise: got %b want 1", awvalid);
        end
        k = 0;
        while (done_cnt == 0 && k < 20) begin nclk(); k++; end
        pclk(); nclk();
        n_checks++;
        if ({dma_done, dma_busy, dma_err} !== 3'b000) begin
            n_errors++; $display("FAIL single_after_done: got done/busy/err %b want 000", {dma_done, dma_busy, dma_err});
        end
        repeat (3) nclk();
        n_checks++;
        if (done_cnt !== 1) begin
            n_errors++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt);
        end
        n_checks++;
        if (aw_cnt !== 1 || aw_addr_log !== 32'h1000_0000 || aw_len_log !== 8'd0) begin
            n_errors++; $display("FAIL single_aw: got cnt %0d addr %h len %0d want 1/10000000/0", aw_cnt, aw_addr_log, aw_len_log);
        end
        n_checks++;
        if (beat_cnt !== 1 || last_log[0] !== 1'b1 || pop_cnt !== 1) begin
            n_errors++; $display("FAIL single_w: got beats %0d last %b pops %0d want 1/1/1", beat_cnt, last_log[0], pop_cnt);
        end
        n_checks++;
        if (wdata_log[0] !== mk(0) || early_w !== 0) begin
            n_errors++; $display("FAIL single_wdata: got %h early %0d want %h/0", wdata_log[0], early_w, mk(0));
        end
    endtask

    task automatic test_full_burst();
        int k;
        pclk();
        awready = 1; wready = 1; out_buf_rd_valid = 1; bvalid = 1; bid = 8'h81; bresp = 2'b00;
        clear_logs();
        start_burst(32'h2000_0010, 4'd15);
        k = 0;
        while (done_cnt == 0 && k < 60) begin nclk(); k++; end
        pclk(); nclk();
        n_checks++;
        if (done_cnt !== 1 || dma_err !== 1'b0) begin
            n_errors++; $display("FAIL full_done: got done %0d err %b want 1/0", done_cnt, dma_err);
        end
        n_checks++;
        if (aw_addr_log !== 32'h2000_0000 || aw_len_log !== 8'd15) begin
            n_errors++; $display("FAIL full_aw: got addr %h len %0d want 20000000/15", aw_addr_log, aw_len_log);
        end
        n_checks++;
        if (beat_cnt !== 16 || pop_cnt !== 16) begin
            n_errors++; $display("FAIL full_counts: got beats %0d pops %0d want 16/16", beat_cnt, pop_cnt);
        end
        n_checks++;
        if (last_cnt !== 1 || last_log[15] !== 1'b1) begin
            n_errors++; $display("FAIL full_wlast: got %0d lasts, beat16 last %b want 1/1", last_cnt, last_log[15]);
        end
        n_checks++;
        if (beat_cyc[15] - beat_cyc[0] !== 15) begin
            n_errors++; $display("FAIL full_throughput: got span %0d want 15", beat_cyc[15] - beat_cyc[0]);
        end
        n_checks++;
        if (wdata_log[7] !== mk(7) || wdata_log[15] !== mk(15)) begin
            n_errors++; $display("FAIL full_wdata: got %h / %h", wdata_log[7], wdata_log[15]);
        end
    endtask

    task automatic test_backpressure();
        int k;
        pclk();
        awready = 1; wready = 0; out_buf_rd_valid = 1; bvalid = 1; bid = 8'h81; bresp = 2'b00;
        clear_logs();
        start_burst(32'h3000_0000, 4'd3);
        k = 0;
        while (done_cnt == 0 && k < 40) begin
            pclk();
            wready = (k % 2 == 0);
            out_buf_rd_valid = !(k == 3 || k == 4);
            nclk();
            if (k == 3) begin
                n_checks++;
                if (wvalid !== 1'b0) begin
                    n_errors++; $display("FAIL bp_empty_wvalid: got %b want 0", wvalid);
                end
            end
            k++;
        end
        pclk();
        wready = 1; out_buf_rd_valid = 1;
        nclk();
        n_checks++;
        if (beat_cnt !== 4 || pop_cnt !== 4 || bad_pop !== 0) begin
            n_errors++; $display("FAIL bp_counts: got beats %0d pops %0d bad %0d want 4/4/0", beat_cnt, pop_cnt, bad_pop);
        end
        n_checks++;
        if (stall_viol !== 0) begin
            n_errors++; $display("FAIL bp_wdata_stable: got %0d changes want 0", stall_viol);
        end
        n_checks++;
        if (last_cnt !== 1 || last_log[3] !== 1'b1 || wdata_log[3] !== mk(3)) begin
            n_errors++; $display("FAIL bp_last: got lasts %0d last3 %b data %h", last_cnt, last_log[3], wdata_log[3]);
        end
        n_checks++;
        if (done_cnt !== 1 || aw_len_log !== 8'd3) begin
            n_errors++; $display("FAIL bp_done: got done %0d awlen %0d want 1/3", done_cnt, aw_len_log);
        end
    endtask

    task automatic test_resp_filter();
        int k;
        pclk();
        awready = 1; wready = 1; out_buf_rd_valid = 1; bvalid = 0; bid = 8'h00; bresp = 2'b00;
        clear_logs();
        start_burst(32'h5000_0000, 4'd0);
        k = 0;
        while (beat_cnt == 0 && k < 20) begin nclk(); k++; end
        pclk();
        bvalid = 1; bid = 8'h80;
        for (int i = 0; i < 3; i++) begin
            nclk();
            n_checks++;
            if ({bready, dma_done, dma_busy} !== 3'b001) begin
                n_errors++; $display("FAIL resp_foreign_%0d: got bready/done/busy %b want 001", i, {bready, dma_done, dma_busy});
            end
            pclk();
        end
        bid = 8'h81; bresp = AXI_RESP_SLVERR;
        dma_start = 1; dma_addr = 32'h6000_0000; dma_burst_len = 4'd2;
        nclk();
        n_checks++;
        if ({bready, dma_done} !== 2'b11) begin
            n_errors++; $display("FAIL resp_accept: got bready/done %b want 11", {bready, dma_done});
        end
        pclk();
        bvalid = 0; dma_start = 0; bresp = 2'b00;
        nclk();
        n_checks++;
        if ({dma_err, dma_busy, dma_done} !== 3'b100) begin
            n_errors++; $display("FAIL resp_err_set: got err/busy/done %b want 100", {dma_err, dma_busy, dma_done});
        end
        repeat (3) pclk();
        nclk();
        n_checks++;
        if (dma_err !== 1'b1 || aw_cnt !== 1 || done_cnt !== 1) begin
            n_errors++; $display("FAIL resp_err_sticky: got err %b aw %0d done %0d want 1/1/1", dma_err, aw_cnt, done_cnt);
        end
        bvalid = 1; bid = 8'h81; bresp = 2'b00;
        start_burst(32'h7000_0000, 4'd0);
        nclk();
        n_checks++;
        if (dma_err !== 1'b0) begin
            n_errors++; $display("FAIL resp_err_clear: got %b want 0", dma_err);
        end
        k = 0;
        while (done_cnt < 2 && k < 20) begin nclk(); k++; end
        pclk(); nclk();
        n_checks++;
        if (done_cnt !== 2 || dma_err !== 1'b0 || dma_busy !== 1'b0) begin
            n_errors++; $display("FAIL resp_clean_run: got done %0d err %b busy %b want 2/0/0", done_cnt, dma_err, dma_busy);
        end
    endtask

    task automatic test_ignored_start_and_reset();
        int k;
        pclk();
        awready = 0; wready = 0; out_buf_rd_valid = 1; bvalid = 0; bid = 8'h81; bresp = 2'b00;
        clear_logs();
        start_burst(32'h3000_0000, 4'd7);
        for (int i = 0; i < 3; i++) begin
            nclk();
            n_checks++;
            if (awvalid !== 1'b1 || awaddr !== 32'h3000_0000 || wvalid !== 1'b0) begin
                n_errors++; $display("FAIL aw_hold_%0d: got awvalid %b addr %h wvalid %b", i, awvalid, awaddr, wvalid);
            end
            pclk();
        end
        awready = 1;
        nclk();
        pclk();
        awready = 0; wready = 1;
        nclk();
        pclk();
        wready = 0; dma_start = 1; dma_addr = 32'hFFFF_FFE0; dma_burst_len = 4'd2;
        nclk();
        pclk();
        dma_start = 0; wready = 1;
        nclk();
        n_checks++;
        if (awvalid !== 1'b0 || dma_busy !== 1'b1 || awlen !== 8'd7) begin
            n_errors++; $display("FAIL ignored_start: got awvalid %b busy %b awlen %0d want 0/1/7", awvalid, dma_busy, awlen);
        end
        pclk();
        wready = 0; rst = 1;
        nclk();
        pclk();
        rst = 0;
        nclk();
        n_checks++;
        if ({awvalid, wvalid, bready, dma_busy, dma_done, dma_err} !== 6'b0) begin
            n_errors++; $display("FAIL midburst_reset: got %b want 000000", {awvalid, wvalid, bready, dma_busy, dma_done, dma_err});
        end
        n_checks++;
        if (beat_cnt !== 2 || aw_cnt !== 1 || done_cnt !== 0 || early_w !== 0) begin
            n_errors++; $display("FAIL midburst_log: got beats %0d aw %0d done %0d early %0d want 2/1/0/0", beat_cnt, aw_cnt, done_cnt, early_w);
        end
        repeat (2) pclk();
        awready = 1; wready = 1; bvalid = 1; bid = 8'h81; bresp = 2'b00;
        clear_logs();
        start_burst(32'h4000_0040, 4'd1);
        k = 0;
        while (done_cnt == 0 && k < 30) begin nclk(); k++; end
        pclk(); nclk();
        n_checks++;
        if (aw_cnt !== 1 || aw_addr_log !== 32'h4000_0040 || aw_len_log !== 8'd1) begin
            n_errors++; $display("FAIL restart_aw: got cnt %0d addr %h len %0d want 1/40000040/1", aw_cnt, aw_addr_log, aw_len_log);
        end
        n_checks++;
        if (beat_cnt !== 2 || last_log[0] !== 1'b0 || last_log[1] !== 1'b1 || wdata_log[0] !== mk(0)) begin
            n_errors++; $display("FAIL restart_w: got beats %0d last %b%b", beat_cnt, last_log[0], last_log[1]);
        end
        n_checks++;
        if (done_cnt !== 1 || dma_err !== 1'b0 || dma_busy !== 1'b0) begin
            n_errors++; $display("FAIL restart_done: got done %0d err %b busy %b want 1/0/0", done_cnt, dma_err, dma_busy);
        end
    endtask

    initial begin
        rst = 1; dma_start = 0; dma_addr = '0; dma_burst_len = '0;
        out_buf_rd_valid = 0; awready = 0; wready = 0;
        bid = '0; bresp = '0; bvalid = 0;
        test_reset();
        test_single_beat();
        test_full_burst();
        test_backpressure();
        test_resp_filter();
        test_ignored_start_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
